fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter and fetch controller that drives the 8-bit address of the instruction ROM and sequences execution of one 8-bit instruction per cycle.
- Launches one of three resident programs on a start request: multiply, string match or closest pair.
- Resolves the forward branch and backward branch instructions using the datapath's condition flag, and detects halt.
- Reports busy, done and error status, plus a retired-instruction count, to the testbench/top level.

Parameters:
- ENTRY0, 0, start address of program 1 (multiply).
- ENTRY1, 93, start address of program 2 (string match).
- ENTRY2, 139, start address of program 3 (closest pair).
- LAST_ADDR, 197, highest valid ROM address; fetching beyond this is an error.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start_i  in  1  launch request; sampled only in IDLE, HALT or ERR.
- prog_sel_i  in  2  program select: 0, 1 or 2; value 3 is illegal.
- inst_i  in  8  instruction from ROM data_o for the address on pc_o (combinational ROM).
- stall_i  in  1  datapath hold; freezes pc and the counter.
- cond_flag_i  in  1  registered seq-result flag from the datapath.
- branch_reg_i  in  8  value of the register named in the branch instruction's low 3 bits.
- pc_o  out  8  registered ROM address.
- inst_valid_o  out  1  high when inst_i executes this cycle.
- busy_o  out  1  high in RUN.
- done_o  out  1  high while in HALT.
- err_o  out  1  high while in ERR.
- icount_o  out  CNT_W  instructions retired since the last start.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, pc_o=0, icount_o=0.
  - inst_valid_o=0, busy_o=0, done_o=0, err_o=0.
  - Takes effect from any state, including mid-RUN; the in-flight instruction is discarded.
- States are IDLE, RUN, HALT and ERR. Outputs are decoded from the state: busy_o=RUN, done_o=HALT, err_o=ERR, inst_valid_o=RUN & ~stall_i.
- IDLE/HALT/ERR with start_i=1:
  - If prog_sel_i is 0, 1 or 2, the next state is RUN with pc_o set to ENTRYn and icount_o cleared.
  - If prog_sel_i is 3, the next state is ERR with pc_o unchanged.
  - start_i during RUN is ignored.
- RUN with stall_i=1: pc_o and icount_o hold, and no decode takes effect.
- RUN with stall_i=0, the instruction decode of inst_i is:
  - 8'h88 (halt): next state HALT, pc_o holds, icount_o+1.
  - 5'b11110 followed by rrr (branch forward): if cond_flag_i=1, pc_o becomes pc+1+branch_reg_i; otherwise pc+1.
  - 5'b10110 followed by rrr (branch backward): if cond_flag_i=1, pc_o becomes pc+1-branch_reg_i; otherwise pc+1.
  - Any other instruction: pc_o becomes pc+1.
  - Every non-halt retire increments icount_o by 1.
- Arithmetic and counter rules:
  - All pc arithmetic is 8-bit modulo 256; wrap-around is legal arithmetic.
  - If the resulting next pc is greater than LAST_ADDR, the next state is ERR and pc_o is loaded with the offending address so it can be inspected.
  - icount_o saturates at all-ones and does not wrap.
- Latency:
  - From start_i, the first instruction address appears on pc_o 1 cycle later.
  - Each taken or not-taken branch resolves in the same cycle with zero bubbles, since the ROM is combinational.
- Simultaneous events: reset_n=0 beats start_i, which beats stall_i. In HALT/ERR, a start_i relaunches directly without passing through IDLE.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, RUN, HALT, ERR};
  - constants OP_HALT=8'h88, BR_FWD_PFX=5'b11110, BR_BWD_PFX=5'b10110;
  - default entry addresses and LAST_ADDR.
- One sub-module, pc_next_calc: combinational next-pc and bounds check.
  - Inputs: pc, inst, cond_flag, branch_reg, stall.
  - Outputs: next_pc, is_halt, out_of_range.
  - The FSM and counter stay in fetch_sequencer.

Test Plan:
- Reset mid-run: start prog 0, run 10 cycles, then reset_n=0 for one edge -> pc_o=0, state IDLE, busy_o=0, icount_o=0.
- Backward branch, taken: start prog 1, drive inst_i=8'hB7 at pc 126 with cond_flag_i=1 and branch_reg_i=25 -> next pc_o=102. With cond_flag_i=0 -> 127.
- Forward branch, taken: at pc 17 with inst_i=8'hF7, cond_flag_i=1 and branch_reg_i=6 -> pc_o=24. At pc 119 with branch_reg_i=10 -> 130.
- Halt and relaunch: at pc 92 with inst_i=8'h88 -> done_o=1 next cycle, pc_o holds 92, icount_o counts the halt. Then start_i with prog_sel_i=2 -> pc_o=139, done_o=0.
- Stall: assert stall_i for 3 cycles at pc 40 -> pc_o=40 and icount_o unchanged throughout, inst_valid_o=0; the pc advances on the first cycle after release.
- Errors:
  - prog_sel_i=3 with start_i -> err_o=1, busy_o=0.
  - Forward branch at pc 190 with branch_reg_i=20 -> next pc 211 > 197 -> ERR with pc_o=211.
  - Backward branch at pc 5 with branch_reg_i=10 -> 252 -> ERR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer.
//   - fetch_state_e : controller states
//   - OP_HALT, BR_FWD_PFX, BR_BWD_PFX : instruction encodings
//   - default entry points, last valid ROM address, counter width
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

    localparam logic [7:0] OP_HALT    = 8'h88;
    localparam logic [4:0] BR_FWD_PFX = 5'b11110;
    localparam logic [4:0] BR_BWD_PFX = 5'b10110;

    localparam logic [7:0] ENTRY0_DEF    = 8'd0;
    localparam logic [7:0] ENTRY1_DEF    = 8'd93;
    localparam logic [7:0] ENTRY2_DEF    = 8'd139;
    localparam logic [7:0] LAST_ADDR_DEF = 8'd197;
    localparam int         CNT_W_DEF     = 16;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-pc computation and ROM bounds check.
// Ports:
//   pc           in  8  current ROM address
//   inst         in  8  instruction fetched at pc
//   cond_flag    in  1  datapath condition flag (branch taken when 1)
//   branch_reg   in  8  branch displacement register value
//   stall        in  1  datapath hold; next_pc equals pc
//   next_pc      out 8  address to fetch next (mod 256)
//   is_halt      out 1  instruction is halt and is executing
//   out_of_range out 1  next_pc lies beyond LAST_ADDR
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter logic [7:0] LAST_ADDR = LAST_ADDR_DEF
) (
    input  logic [7:0] pc,
    input  logic [7:0] inst,
    input  logic       cond_flag,
    input  logic [7:0] branch_reg,
    input  logic       stall,
    output logic [7:0] next_pc,
    output logic       is_halt,
    output logic       out_of_range
);

    logic [7:0] pc_inc_s;

    assign pc_inc_s = pc + 8'd1;

    // Decode the executing instruction into the next fetch address.
    always_comb begin
        next_pc = pc;
        is_halt = 1'b0;
        if (stall) begin
            next_pc = pc;
        end else if (inst == OP_HALT) begin
            is_halt = 1'b1;
            next_pc = pc;
        end else if (inst[7:3] == BR_FWD_PFX) begin
            next_pc = cond_flag ? (pc_inc_s + branch_reg) : pc_inc_s;
        end else if (inst[7:3] == BR_BWD_PFX) begin
            next_pc = cond_flag ? (pc_inc_s - branch_reg) : pc_inc_s;
        end else begin
            next_pc = pc_inc_s;
        end
    end

    assign out_of_range = (next_pc > LAST_ADDR);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the instruction ROM.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   start_i        launch request (honoured outside RUN)
//   prog_sel_i[1:0] program select 0..2, 3 is illegal
//   inst_i[7:0]    instruction at pc_o
//   stall_i        freeze pc and counter
//   cond_flag_i    branch condition
//   branch_reg_i   branch displacement
//   pc_o           registered ROM address
//   inst_valid_o   inst_i executes this cycle
//   busy_o/done_o/err_o  RUN / HALT / ERR status
//   icount_o       saturating retired-instruction count since start
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [7:0] ENTRY0    = ENTRY0_DEF,
    parameter logic [7:0] ENTRY1    = ENTRY1_DEF,
    parameter logic [7:0] ENTRY2    = ENTRY2_DEF,
    parameter logic [7:0] LAST_ADDR = LAST_ADDR_DEF,
    parameter int         CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [1:0]       prog_sel_i,
    input  logic [7:0]       inst_i,
    input  logic             stall_i,
    input  logic             cond_flag_i,
    input  logic [7:0]       branch_reg_i,
    output logic [7:0]       pc_o,
    output logic             inst_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] icount_o
);

    fetch_state_e     state_r, state_nxt_s;
    logic [7:0]       pc_r, pc_nxt_s;
    logic [CNT_W-1:0] icount_r;
    logic             cnt_clr_s, cnt_inc_s;
    logic             busy_r, done_r, err_r;
    logic [7:0]       calc_pc_s;
    logic             is_halt_s, out_of_range_s;

    pc_next_calc #(.LAST_ADDR(LAST_ADDR)) u_pc_next_calc (
        .pc           (pc_r),
        .inst         (inst_i),
        .cond_flag    (cond_flag_i),
        .branch_reg   (branch_reg_i),
        .stall        (stall_i),
        .next_pc      (calc_pc_s),
        .is_halt      (is_halt_s),
        .out_of_range (out_of_range_s)
    );

    // Next-state, next-pc and counter control.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            IDLE, HALT, ERR: begin
                if (start_i) begin
                    case (prog_sel_i)
                        2'd0: begin
                            state_nxt_s = RUN;
                            pc_nxt_s    = ENTRY0;
                            cnt_clr_s   = 1'b1;
                        end
                        2'd1: begin
                            state_nxt_s = RUN;
                            pc_nxt_s    = ENTRY1;
                            cnt_clr_s   = 1'b1;
                        end
                        2'd2: begin
                            state_nxt_s = RUN;
                            pc_nxt_s    = ENTRY2;
                            cnt_clr_s   = 1'b1;
                        end
                        default: begin
                            // Illegal program select: pc keeps its value.
                            state_nxt_s = ERR;
                        end
                    endcase
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (stall_i) begin
                    state_nxt_s = RUN;
                end else if (is_halt_s) begin
                    state_nxt_s = HALT;
                    cnt_inc_s   = 1'b1;
                end else if (out_of_range_s) begin
                    // Keep the offending address visible on pc_o.
                    state_nxt_s = ERR;
                    pc_nxt_s    = calc_pc_s;
                    cnt_inc_s   = 1'b1;
                end else begin
                    pc_nxt_s  = calc_pc_s;
                    cnt_inc_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pc, counter and status flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            pc_r     <= 8'd0;
            icount_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == HALT);
            err_r   <= (state_nxt_s == ERR);
            if (cnt_clr_s) begin
                icount_r <= '0;
            end else if (cnt_inc_s && (icount_r != {CNT_W{1'b1}})) begin
                icount_r <= icount_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                icount_r <= icount_r;
            end
        end
    end

    assign pc_o         = pc_r;
    assign icount_o     = icount_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign inst_valid_o = (state_r == RUN) & ~stall_i;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start_i;
    logic [1:0]  prog_sel_i;
    logic [7:0]  inst_i;
    logic        stall_i;
    logic        cond_flag_i;
    logic [7:0]  branch_reg_i;
    logic [7:0]  pc_o;
    logic        inst_valid_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] icount_o;

    fetch_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .prog_sel_i   (prog_sel_i),
        .inst_i       (inst_i),
        .stall_i      (stall_i),
        .cond_flag_i  (cond_flag_i),
        .branch_reg_i (branch_reg_i),
        .pc_o         (pc_o),
        .inst_valid_o (inst_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .icount_o     (icount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: abstract machine status plus plain integers.
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;
    int m_state = M_IDLE;
    int m_pc    = 0;
    int m_cnt   = 0;
    bit m_known = 1'b0;
    int entry [3] = '{0, 93, 139};

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input int sel, input int ins,
                              input bit stl, input bit cnd, input int br);
        int t;
        if (!rst) begin
            m_state = M_IDLE; m_pc = 0; m_cnt = 0; m_known = 1'b1;
        end else if (m_state != M_RUN) begin
            if (st) begin
                if (sel == 3) m_state = M_ERR;
                else begin m_state = M_RUN; m_pc = entry[sel]; m_cnt = 0; end
            end
        end else if (!stl) begin
            if (m_cnt < 65535) m_cnt++;
            if (ins == 136) begin
                m_state = M_HALT;
            end else begin
                t = m_pc + 1;
                if (cnd && (ins / 8) == 30) t = t + br;   // 11110rrr
                if (cnd && (ins / 8) == 22) t = t - br;   // 10110rrr
                t = t & 255;
                m_pc = t;
                if (t > 197) m_state = M_ERR;
            end
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit st, input int sel, input int ins,
                               input bit stl, input bit cnd, input int br);
        reset_n = rst; start_i = st; prog_sel_i = 2'(sel); inst_i = 8'(ins);
        stall_i = stl; cond_flag_i = cnd; branch_reg_i = 8'(br);
        #1;
        if (m_known) check_value("inst_valid", int'(inst_valid_o),
                                 (m_state == M_RUN && !stl) ? 1 : 0);
        @(posedge clk);
        #1;
        model_step(rst, st, sel, ins, stl, cnd, br);
        if (m_known) begin
            check_value("pc", int'(pc_o), m_pc);
            check_value("busy", int'(busy_o), (m_state == M_RUN) ? 1 : 0);
            check_value("done", int'(done_o), (m_state == M_HALT) ? 1 : 0);
            check_value("err", int'(err_o), (m_state == M_ERR) ? 1 : 0);
            check_value("icount", int'(icount_o), m_cnt);
        end
    endtask

    task automatic nop();
        drive_cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic launch(input int sel);
        drive_cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0);
        drive_cycle(1'b1, 1'b1, sel, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_pc != target && guard < 300) begin
            nop();
            guard++;
        end
        check_value("run_to_pc", int'(pc_o), target);
    endtask

    initial begin
        reset_n = 1'b0; start_i = 1'b0; prog_sel_i = 2'd0; inst_i = 8'h00;
        stall_i = 1'b0; cond_flag_i = 1'b0; branch_reg_i = 8'd0;

        // Reset state
        drive_cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0);
        check_value("rst_pc", int'(pc_o), 0);
        check_value("rst_busy", int'(busy_o), 0);

        // Reset mid-run
        launch(0);
        repeat (10) nop();
        check_value("run10_pc", int'(pc_o), 10);
        drive_cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0);
        check_value("midrst_pc", int'(pc_o), 0);
        check_value("midrst_busy", int'(busy_o), 0);
        check_value("midrst_icount", int'(icount_o), 0);

        // Backward branch, taken and not taken
        launch(1);
        check_value("entry1", int'(pc_o), 93);
        run_to(126);
        drive_cycle(1'b1, 1'b0, 0, 8'hB7, 1'b0, 1'b1, 25);
        check_value("bwd_taken", int'(pc_o), 102);
        run_to(126);
        drive_cycle(1'b1, 1'b0, 0, 8'hB7, 1'b0, 1'b0, 25);
        check_value("bwd_not_taken", int'(pc_o), 127);

        // Forward branch, taken
        launch(0);
        run_to(17);
        drive_cycle(1'b1, 1'b0, 0, 8'hF7, 1'b0, 1'b1, 6);
        check_value("fwd_taken_17", int'(pc_o), 24);
        run_to(119);
        drive_cycle(1'b1, 1'b0, 0, 8'hF7, 1'b0, 1'b1, 10);
        check_value("fwd_taken_119", int'(pc_o), 130);

        // Halt and relaunch from HALT
        launch(0);
        run_to(92);
        drive_cycle(1'b1, 1'b0, 0, 8'h88, 1'b0, 1'b0, 0);
        check_value("halt_done", int'(done_o), 1);
        check_value("halt_pc", int'(pc_o), 92);
        check_value("halt_icount", int'(icount_o), 93);
        drive_cycle(1'b1, 1'b1, 2, 8'h00, 1'b0, 1'b0, 0);
        check_value("relaunch_pc", int'(pc_o), 139);
        check_value("relaunch_done", int'(done_o), 0);

        // Stall holds pc and counter
        launch(0);
        run_to(40);
        repeat (3) begin
            drive_cycle(1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0);
            check_value("stall_pc", int'(pc_o), 40);
            check_value("stall_icount", int'(icount_o), 40);
        end
        nop();
        check_value("unstall_pc", int'(pc_o), 41);

        // Illegal program select
        launch(3);
        check_value("sel3_err", int'(err_o), 1);
        check_value("sel3_busy", int'(busy_o), 0);

        // Forward branch out of range
        launch(2);
        run_to(190);
        drive_cycle(1'b1, 1'b0, 0, 8'hF7, 1'b0, 1'b1, 20);
        check_value("fwd_oor_err", int'(err_o), 1);
        check_value("fwd_oor_pc", int'(pc_o), 211);

        // Backward branch wrapping below zero
        launch(0);
        run_to(5);
        drive_cycle(1'b1, 1'b0, 0, 8'hB7, 1'b0, 1'b1, 10);
        check_value("bwd_wrap_err", int'(err_o), 1);
        check_value("bwd_wrap_pc", int'(pc_o), 252);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r, ins;
            bit rst, st, stl, cnd;
            r = int'($urandom_range(0, 15));
            if (r == 0)      ins = 136;
            else if (r < 4)  ins = 240 + int'($urandom_range(0, 7));
            else if (r < 7)  ins = 176 + int'($urandom_range(0, 7));
            else             ins = int'($urandom_range(0, 255));
            rst = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 3) == 0);
            stl = ($urandom_range(0, 3) == 0);
            cnd = $urandom_range(0, 1) != 0;
            drive_cycle(rst, st, int'($urandom_range(0, 3)), ins, stl, cnd,
                        int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
